// File: rtl/mem_arb_pkg.sv
// Shared types for the memory request arbiter: FSM state and operation kind.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless N-way round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned SW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last_grant,
    output logic          grant_valid,
    output logic [SW-1:0] grant_idx
);

    logic [SW-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = SW'((32'(last_grant) + off) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Funnels per-cache fill/write-back requests onto one memory port, one
// transaction outstanding at a time, round-robin across caches.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned AW = 32,
    localparam int unsigned SW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  mem_read,
    input  logic [N-1:0]  mem_write,
    input  logic [AW-1:0] addr [N],
    output logic [N-1:0]  busy,
    output logic [N-1:0]  done,
    output logic [N-1:0]  drop_err,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [SW-1:0] m_src,
    input  logic          m_resp
);

    arb_state_t    state, state_nxt;
    logic [N-1:0]  rd_pend, wr_pend;
    logic [AW-1:0] rd_addr [N];
    logic [AW-1:0] wr_addr [N];
    logic [N-1:0]  clr_rd, clr_wr;
    logic [SW-1:0] last_grant, src_q;
    op_t           cur_op;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          load, resp_fire;

    assign busy  = rd_pend | wr_pend;
    assign m_we  = (cur_op == OP_WR);
    assign m_src = src_q;

    rr_arbiter #(.N(N)) u_rr (
        .req         (busy),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   if (m_ready)     state_nxt = WAIT;
            WAIT:    if (m_resp)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_valid   = (state == ISSUE);
        load      = (state == IDLE) && grant_valid;
        resp_fire = (state == WAIT) && m_resp;
    end

    always_comb begin
        clr_rd = '0;
        clr_wr = '0;
        if (resp_fire) begin
            if (cur_op == OP_WR) clr_wr[src_q] = 1'b1;
            else                 clr_rd[src_q] = 1'b1;
        end
    end

    // A request landing on a slot being retired this cycle is accepted, not dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= '0;
            wr_pend  <= '0;
            drop_err <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                rd_addr[i] <= '0;
                wr_addr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (mem_read[i] && (!rd_pend[i] || clr_rd[i])) begin
                    rd_pend[i] <= 1'b1;
                    rd_addr[i] <= addr[i];
                end else if (clr_rd[i]) begin
                    rd_pend[i] <= 1'b0;
                end
                if (mem_write[i] && (!wr_pend[i] || clr_wr[i])) begin
                    wr_pend[i] <= 1'b1;
                    wr_addr[i] <= addr[i];
                end else if (clr_wr[i]) begin
                    wr_pend[i] <= 1'b0;
                end
                if ((mem_read[i] && rd_pend[i] && !clr_rd[i]) ||
                    (mem_write[i] && wr_pend[i] && !clr_wr[i]))
                    drop_err[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_op     <= OP_RD;
            m_addr     <= '0;
            src_q      <= '0;
            last_grant <= SW'(N - 1);
            done       <= '0;
        end else begin
            done <= '0;
            if (load) begin
                src_q  <= grant_idx;
                cur_op <= wr_pend[grant_idx] ? OP_WR : OP_RD;
                m_addr <= wr_pend[grant_idx] ? wr_addr[grant_idx] : rd_addr[grant_idx];
            end
            if (resp_fire) begin
                last_grant  <= src_q;
                done[src_q] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter N, default 2: number of cache controllers served (N >= 2).
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 mem_read  input  N  per-cache line-fill request, sampled every cycle.
REQ-006 mem_write  input  N  per-cache write-back request, sampled every cycle.
REQ-007 addr  input  AW x N (unpacked)  per-cache request address.
REQ-008 busy  output  N  cache i has at least one pending operation.
REQ-009 done  output  N  one-cycle completion pulse for cache i.
REQ-010 drop_err  output  N  sticky: a request from cache i was dropped.
REQ-011 m_valid  output  1  memory request valid.
REQ-012 m_ready  input  1  memory accepts the request.
REQ-013 m_we  output  1  1 = write-back, 0 = fill.
REQ-014 m_addr  output  AW  memory request address.
REQ-015 m_src  output  max(1, clog2 N)  index of the granted cache.
REQ-016 m_resp  input  1  one-cycle memory completion strobe.

Function
REQ-017 Each cache shall have two slots, rd_pend/rd_addr and wr_pend/wr_addr; mem_read[i] shall set rd_pend[i] and latch addr[i], and mem_write[i] shall set wr_pend[i] and latch addr[i].
REQ-018 Simultaneous mem_read[i] and mem_write[i] shall fill both slots in the same cycle.
REQ-019 A request arriving while its slot is already pending shall be dropped, shall set drop_err[i], and shall leave the latched address unchanged.
REQ-020 A new request arriving in the same cycle its slot is cleared shall be accepted; set wins over clear.
REQ-021 busy[i] = rd_pend[i] | wr_pend[i], combinational from the slot registers.
REQ-022 FSM states shall be IDLE, ISSUE and WAIT.
REQ-023 IDLE: if any slot is pending, select cache i round-robin starting at last_grant+1 (mod N), write before read within that cache, register m_we/m_addr/m_src, raise m_valid, and go to ISSUE; otherwise stay in IDLE.
REQ-024 ISSUE: m_valid and all m_* fields shall be held stable until m_valid & m_ready, then go to WAIT.
REQ-025 WAIT: on m_resp, clear the served slot, update last_grant to i, pulse done[i] in the following cycle, and go to IDLE.
REQ-026 m_resp outside WAIT shall be ignored; m_ready outside ISSUE shall be ignored.
REQ-027 Latency: a request sampled at edge E0 shall see m_valid high after E1 at the earliest; done shall pulse one cycle after m_resp.
REQ-028 Only one memory transaction shall be outstanding at any time.
REQ-029 A cache with both slots pending shall get its write served, then yield round-robin to other pending caches before its read is served.

Reset
REQ-030 While rst is high, asynchronously: FSM = IDLE, all slots clear, last_grant = N-1 (cache 0 first), m_valid/m_we/done/busy/drop_err = 0, m_addr/m_src = 0.
REQ-031 Reset mid-transaction shall abandon the transaction with no done pulse; m_resp arriving after reset is ignored.

Structure
REQ-032 Package mem_arb_pkg shall hold the FSM state enum typedef and the op-type typedef (OP_RD, OP_WR).
REQ-033 Sub-module rr_arbiter shall implement the N-way round-robin pick from a request vector and last_grant; it has no state of its own.

Verification
REQ-034 Single fill: mem_read[0] pulse with addr[0]=0x100, m_ready=1, m_resp 3 cycles after accept -> one beat m_we=0, m_addr=0x100, m_src=0; done[0] one cycle after m_resp.
REQ-035 Contention: mem_write[0] (0x200) and mem_write[1] (0x300) in the same cycle after reset -> cache 0 served first, then cache 1; done[0] precedes done[1].
REQ-036 Both ops from one cache: mem_read[1]=mem_write[1]=1, addr=0x40 -> write issued first, then read; busy[1] high until the second done.
REQ-037 Backpressure: m_ready low for 5 cycles -> m_valid and fields held stable; exactly one transaction accepted.
REQ-038 Drop: second mem_read[0] (addr 0x500) while rd_pend[0]=1 (addr 0x100) -> drop_err[0]=1 and the issued address stays 0x100.
REQ-039 Reset in WAIT: assert rst before m_resp -> m_valid/busy = 0 immediately, no done; a later m_resp is ignored.
